// File: rtl/key_debounce.sv
// key_debounce: multi-channel key debouncer with press/release pulses and a
// sticky press-pending flag.
//
// Each channel accepts a new level only after STABLE_CYCLES consecutive
// samples that differ from the current level. Any sample equal to the
// current level restarts the count.
//
// Optional build macro: KEY_DEBOUNCE_SYNC_EN. When defined, every key_in bit
// passes through an internal two-flop synchroniser first, which adds 2 cycles
// of latency. When undefined, key_in must already be synchronous to clk.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   key_in      in   N  key levels, 1 = pressed
//   pend_ack    in   N  per-channel clear of pend
//   key_level   out  N  debounced level
//   key_press   out  N  one-cycle pulse on accepted 0->1
//   key_release out  N  one-cycle pulse on accepted 1->0
//   pend        out  N  sticky press-pending flag
module key_debounce #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  input  logic [N-1:0] pend_ack,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] pend
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  w_sample;
  logic [N-1:0]  w_accept;
  logic [N-1:0]  w_press_nxt;
  logic [N-1:0]  r_level;
  logic [N-1:0]  r_press;
  logic [N-1:0]  r_release;
  logic [N-1:0]  r_pend;
  logic [CW-1:0] r_cnt [N];

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = key_in;
`endif

  // A channel accepts its sample on the edge where the count has reached the
  // terminal value and the sample still differs from the level.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N; i++) begin
      w_accept[i] = (w_sample[i] != r_level[i]) && (r_cnt[i] == TC);
    end
    w_press_nxt = w_accept & w_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_pend    <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_sample[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_level   <= r_level ^ w_accept;
      r_press   <= w_press_nxt;
      r_release <= w_accept & ~w_sample;
      // A press on the same edge as an ack keeps the flag set.
      r_pend    <= w_press_nxt | (r_pend & ~pend_ack);
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign pend        = r_pend;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with N = 2, STABLE_CYCLES = 4.
// Table-driven vectors cover the main sequences in the default build;
// hand-written sequences cover clean press latency, glitch, bounce and
// reset mid-operation, and adapt latency when KEY_DEBOUNCE_SYNC_EN is set.
module tb_key_debounce;

  localparam int N  = 2;
  localparam int SC = 4;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int LAT = SC + 2;
`else
  localparam int LAT = SC;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] pend_ack;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] pend;

  int n_pass  = 0;
  int n_total = 0;

  key_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .pend_ack   (pend_ack),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [1:0] k;
    logic [1:0] a;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] pnd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] k, input logic [1:0] a,
                     input logic [1:0] lvl, input logic [1:0] prs,
                     input logic [1:0] rel, input logic [1:0] pnd);
    vec_t v;
    v.r = r; v.k = k; v.a = a; v.lvl = lvl; v.prs = prs; v.rel = rel; v.pnd = pnd;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic [1:0] k, input logic [1:0] a);
    @(negedge clk);
    rst = r; key_in = k; pend_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] lvl, input logic [1:0] prs,
                       input logic [1:0] rel, input logic [1:0] pnd);
    logic [7:0] act, exp;
    act = {key_level, key_press, key_release, pend};
    exp = {lvl, prs, rel, pnd};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got lvl/prs/rel/pnd=%b required %b at %0t", name, act, exp, $time);
  endtask

  initial begin
    int npress;
    rst = 1'b1; key_in = '0; pend_ack = '0;

`ifndef KEY_DEBOUNCE_SYNC_EN
    // r    key    ack    lvl    prs    rel    pnd
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // reset
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // E1
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // E2
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00); // E3
    add(0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01); // E4 press ch0
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01); // E5 pulse ends
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01); // release, pend held
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00); // ack clears
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00); // ack with pend=0
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10); // press beats ack
    add(0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
    add(0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00); // ack ch1
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01); // simultaneous events
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].k, vq[i].a);
      check($sformatf("vec%0d", i), vq[i].lvl, vq[i].prs, vq[i].rel, vq[i].pnd);
    end
`endif

    // clean press latency
    step(1, 2'b00, 2'b00);
    check("cp_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int e = 1; e < LAT; e++) begin
      step(0, 2'b01, 2'b00);
      check($sformatf("cp_wait%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end
    step(0, 2'b01, 2'b00);
    check("cp_press", 2'b01, 2'b01, 2'b00, 2'b01);
    step(0, 2'b01, 2'b00);
    check("cp_pulse_end", 2'b01, 2'b00, 2'b00, 2'b01);

    // single-cycle glitch
    step(1, 2'b00, 2'b00);
    step(0, 2'b01, 2'b00);
    for (int e = 0; e < 8; e++) begin
      step(0, 2'b00, 2'b00);
      check($sformatf("glitch%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // bounce: 3 high, 1 low, five times
    for (int b = 0; b < 5; b++) begin
      for (int e = 0; e < 4; e++) begin
        step(0, (e < 3) ? 2'b01 : 2'b00, 2'b00);
        check($sformatf("bounce%0d_%0d", b, e), 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    npress = 0;
    for (int e = 1; e <= LAT; e++) begin
      step(0, 2'b01, 2'b00);
      if (key_press[0]) npress++;
    end
    check("bounce_hold", 2'b01, 2'b01, 2'b00, 2'b01);
    n_total++;
    if (npress == 1) n_pass++;
    else $display("FAIL bounce_press_count: got %0d required 1", npress);
    step(0, 2'b01, 2'b00);
    check("bounce_after", 2'b01, 2'b00, 2'b00, 2'b01);

    // reset mid-count with pend[0] set; both channels differing
    for (int e = 0; e < 3; e++) begin
      step(0, 2'b10, 2'b00);
      check($sformatf("pre_rst%0d", e), 2'b01, 2'b00, 2'b00, 2'b01);
    end
    step(1, 2'b10, 2'b00);
    check("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    for (int e = 1; e < LAT; e++) begin
      step(0, 2'b10, 2'b00);
      check($sformatf("post_rst%0d", e), 2'b00, 2'b00, 2'b00, 2'b00);
    end
    step(0, 2'b10, 2'b00);
    check("post_rst_press", 2'b10, 2'b10, 2'b00, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-channel debouncer and press-event latch for the piano-key buttons. It consumes the two-flop-synchronised button levels and filters contact bounce with a per-channel stability counter. It produces a clean level, one-cycle press and release pulses, and a sticky press-pending flag that game logic clears with an acknowledge. It sits between the input synchronisers and the tile-hit / scoring logic.

## Interface
Parameters:
- `N`, default 4: number of key channels.
- `STABLE_CYCLES`, default 250000: consecutive differing samples required to accept a new level (10 ms at 25 MHz). Legal range ≥1.

Ports:
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `key_in`, input, N: key levels, 1 = pressed. Synchronous to `clk` unless `KEY_DEBOUNCE_SYNC_EN` is defined.
- `pend_ack`, input, N: per-channel clear of `pend`.
- `key_level`, output, N: debounced key level.
- `key_press`, output, N: one-cycle pulse on each accepted 0→1 change of `key_level`.
- `key_release`, output, N: one-cycle pulse on each accepted 1→0 change of `key_level`.
- `pend`, output, N: sticky press-pending flag.

## Operation
- Per-channel state: `key_level` bit plus counter `cnt`. Counter width is max(1, $clog2(STABLE_CYCLES)).
- Each edge, with sample s = the channel's `key_in` bit (or the synchroniser output when the macro is defined):
  - s == `key_level`: `cnt` ← 0.
  - s != `key_level` and `cnt` == STABLE_CYCLES−1: `key_level` ← s and `cnt` ← 0. Also `key_press` ← s and `key_release` ← ~s.
  - s != `key_level` otherwise: `cnt` ← `cnt`+1.
- `key_press` and `key_release` are registered and are 0 on every edge with no level change. They are never high together on one channel.
- Any sample equal to the current level restarts the count. A bounce shorter than STABLE_CYCLES never changes the level.
- `cnt` never exceeds STABLE_CYCLES−1, so there is no wrap-around.
- `pend` logic:
  - `pend` ← 1 on the edge that asserts `key_press`.
  - Otherwise `pend` ← 0 when `pend_ack` = 1.
  - If a press and an ack occur on the same edge, the press wins and `pend` stays 1.
  - `pend_ack` while `pend` = 0 is ignored.
  - Release does not affect `pend`.
- Channels are fully independent, and simultaneous events on different channels are all honoured.
- STABLE_CYCLES = 1: the level follows the sample with one edge of latency. Every change pulses.

## Timing
- Reset: on an edge with `rst` = 1, every output and every `cnt` goes to 0. Synchroniser flops, if present, also go to 0. `rst` overrides all other inputs.
- Reset mid-count discards the partial count. Reset while `pend` = 1 clears it.
- After reset deassertion, a key held at 1 produces a press after STABLE_CYCLES samples, the same as a fresh press.
- Latency without the macro: if `key_in` rises before edge E1 and holds, `key_level`, `key_press` and `pend` go high after edge E_STABLE_CYCLES. `key_press` falls one edge later.
- Latency with the macro: add 2 edges.
- `pend_ack` takes effect on the edge it is sampled. `pend` reads 0 in the next cycle, unless a press occurs on that same edge.

## Configuration
- `KEY_DEBOUNCE_SYNC_EN` defined: each `key_in` bit passes through an internal two-flop synchroniser (reset to 0) before the debounce logic. Raw asynchronous pad signals may be connected directly. Latency +2 cycles.
- Not defined: `key_in` is used directly as s. The upstream synchroniser is responsible for metastability. There is no added latency.

## Test plan
Common setup: N = 2, STABLE_CYCLES = 4, macro undefined unless stated.
- **Clean press:** `key_in[0]` 0→1 before E1, held. Required: `key_level[0]`, `key_press[0]` and `pend[0]` = 1 after E4. `key_press[0]` = 0 after E5. Channel 1 stays all 0.
- **Bounce:** `key_in[0]` = 1 for 3 edges, 0 for 1 edge, repeated 5 times. Required: `key_level[0]` stays 0 and no pulses occur. Then hold 1 for 4 edges; required: a single press pulse.
- **Release and pend:** from pressed with `pend[0]` = 1, drop `key_in[0]` for 4 edges. Required: one `key_release[0]` pulse, `key_level[0]` = 0, and `pend[0]` still 1. Then `pend_ack[0]` for 1 cycle; required: `pend[0]` = 0 next cycle.
- **Ack collision:** assert `pend_ack[1]` on the same edge that `key_press[1]` is generated. Required: `pend[1]` = 1 afterwards. Ack with `pend` = 0 has no effect.
- **Reset mid-operation:** `rst` = 1 for 1 edge after 3 differing samples on both channels, with `pend[0]` = 1. Required: all outputs 0. With keys still held, the press occurs 4 edges after reset release.
- **Sync build:** define `KEY_DEBOUNCE_SYNC_EN` and repeat the clean-press test. Required: press after E6. A 1-cycle glitch on `key_in` produces no output change.
